// File: rtl/mips_defines_pkg.sv
// rtl/mips_defines_pkg.sv - shared MIPS pipeline codes: ALU classes/opcodes, widths, divider states
package mips_defines_pkg;

    localparam int REG_ADDR_WIDTH = 5;
    localparam int REG_DATA_WIDTH = 32;
    localparam int CTRL_WIDTH     = 6;

    localparam logic [2:0] ALUSEL_NOP   = 3'b000;
    localparam logic [2:0] ALUSEL_LOGIC = 3'b001;
    localparam logic [2:0] ALUSEL_SHIFT = 3'b010;
    localparam logic [2:0] ALUSEL_MOVE  = 3'b011;
    localparam logic [2:0] ALUSEL_ARITH = 3'b100;

    localparam logic [7:0] ALUOP_AND   = 8'b0010_0100;
    localparam logic [7:0] ALUOP_OR    = 8'b0010_0101;
    localparam logic [7:0] ALUOP_XOR   = 8'b0010_0110;
    localparam logic [7:0] ALUOP_NOR   = 8'b0010_0111;
    localparam logic [7:0] ALUOP_SLL   = 8'b0111_1100;
    localparam logic [7:0] ALUOP_SRL   = 8'b0000_0010;
    localparam logic [7:0] ALUOP_SRA   = 8'b0000_0011;
    localparam logic [7:0] ALUOP_MFHI  = 8'b0001_0000;
    localparam logic [7:0] ALUOP_MFLO  = 8'b0001_0010;
    localparam logic [7:0] ALUOP_ADDU  = 8'b0010_0001;
    localparam logic [7:0] ALUOP_SUBU  = 8'b0010_0011;
    localparam logic [7:0] ALUOP_SLT   = 8'b0010_1010;
    localparam logic [7:0] ALUOP_SLTU  = 8'b0010_1011;
    localparam logic [7:0] ALUOP_MULT  = 8'b0001_1000;
    localparam logic [7:0] ALUOP_MULTU = 8'b0001_1001;
    localparam logic [7:0] ALUOP_DIV   = 8'b0001_1010;
    localparam logic [7:0] ALUOP_DIVU  = 8'b0001_1011;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_RUN  = 2'd1,
        DIV_DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/div_unit.sv
// rtl/div_unit.sv - multi-cycle restoring divider for DIV/DIVU with flush abort and result hold
module div_unit
    import mips_defines_pkg::*;
#(
    parameter int DATA_WIDTH = REG_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  signed_op,
    input  logic [DATA_WIDTH-1:0] op_a,
    input  logic [DATA_WIDTH-1:0] op_b,
    input  logic                  flush,
    input  logic                  hold,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] quotient,
    output logic [DATA_WIDTH-1:0] remainder
);

    localparam int CNT_W = $clog2(DATA_WIDTH);

    div_state_t            state_q;
    logic [CNT_W-1:0]      count_q;
    logic [DATA_WIDTH-1:0] rem_q;
    logic [DATA_WIDTH-1:0] quot_q;
    logic [DATA_WIDTH-1:0] divisor_q;
    logic                  neg_quot_q;
    logic                  neg_rem_q;
    logic [DATA_WIDTH-1:0] quotient_q;
    logic [DATA_WIDTH-1:0] remainder_q;

    logic [DATA_WIDTH-1:0] mag_a;
    logic [DATA_WIDTH-1:0] mag_b;
    logic [DATA_WIDTH:0]   trial;
    logic                  fits;
    logic [DATA_WIDTH-1:0] rem_next;
    logic [DATA_WIDTH-1:0] quot_next;

    assign mag_a = (signed_op && op_a[DATA_WIDTH-1]) ? -op_a : op_a;
    assign mag_b = (signed_op && op_b[DATA_WIDTH-1]) ? -op_b : op_b;

    // Shifted partial remainder needs one extra bit; once the divisor fits,
    // the difference is below the divisor so a DATA_WIDTH subtract is exact.
    assign trial     = {rem_q, quot_q[DATA_WIDTH-1]};
    assign fits      = trial >= {1'b0, divisor_q};
    assign rem_next  = fits ? (trial[DATA_WIDTH-1:0] - divisor_q) : trial[DATA_WIDTH-1:0];
    assign quot_next = {quot_q[DATA_WIDTH-2:0], fits};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= DIV_IDLE;
            count_q     <= '0;
            rem_q       <= '0;
            quot_q      <= '0;
            divisor_q   <= '0;
            neg_quot_q  <= 1'b0;
            neg_rem_q   <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
        end else if (flush) begin
            state_q <= DIV_IDLE;
        end else begin
            case (state_q)
                DIV_IDLE: begin
                    if (start) begin
                        if (op_b == '0) begin
                            quotient_q  <= '1;
                            remainder_q <= op_a;
                            state_q     <= DIV_DONE;
                        end else begin
                            rem_q      <= '0;
                            quot_q     <= mag_a;
                            divisor_q  <= mag_b;
                            neg_quot_q <= signed_op && (op_a[DATA_WIDTH-1] ^ op_b[DATA_WIDTH-1]);
                            neg_rem_q  <= signed_op && op_a[DATA_WIDTH-1];
                            count_q    <= '0;
                            state_q    <= DIV_RUN;
                        end
                    end
                end
                DIV_RUN: begin
                    rem_q   <= rem_next;
                    quot_q  <= quot_next;
                    count_q <= count_q + 1'b1;
                    if (count_q == CNT_W'(DATA_WIDTH - 1)) begin
                        quotient_q  <= neg_quot_q ? -quot_next : quot_next;
                        remainder_q <= neg_rem_q ? -rem_next : rem_next;
                        state_q     <= DIV_DONE;
                    end
                end
                DIV_DONE: begin
                    if (!hold) begin
                        state_q <= DIV_IDLE;
                    end
                end
                default: state_q <= DIV_IDLE;
            endcase
        end
    end

    assign busy      = !flush && ((state_q == DIV_IDLE && start) || state_q == DIV_RUN);
    assign done      = !flush && (state_q == DIV_DONE);
    assign quotient  = quotient_q;
    assign remainder = remainder_q;

endmodule

// File: rtl/ex_stage.sv
// rtl/ex_stage.sv - MIPS execute stage: combinational ALU/MULT mux plus multi-cycle divider
module ex_stage
    import mips_defines_pkg::*;
#(
    parameter int DATA_WIDTH   = REG_DATA_WIDTH,
    parameter int ALUSEL_WIDTH = 3,
    parameter int ALUOP_WIDTH  = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      ex_stall,
    input  logic                      flush,
    input  logic [REG_ADDR_WIDTH-1:0] reg_wr_addr_in,
    input  logic                      reg_wr_en_in,
    input  logic [DATA_WIDTH-1:0]     reg_rd_data1_in,
    input  logic [DATA_WIDTH-1:0]     reg_rd_data2_in,
    input  logic [ALUSEL_WIDTH-1:0]   alusel_in,
    input  logic [ALUOP_WIDTH-1:0]    aluop_in,
    input  logic [DATA_WIDTH-1:0]     hi_in,
    input  logic [DATA_WIDTH-1:0]     lo_in,
    output logic [REG_ADDR_WIDTH-1:0] reg_wr_addr_out,
    output logic                      reg_wr_en_out,
    output logic [DATA_WIDTH-1:0]     reg_wr_data_out,
    output logic                      hilo_wr_en_out,
    output logic [DATA_WIDTH-1:0]     hi_out,
    output logic [DATA_WIDTH-1:0]     lo_out,
    output logic                      stall_req
);

    localparam int SHAMT_W = $clog2(DATA_WIDTH);

    logic [DATA_WIDTH-1:0]   op_a;
    logic [DATA_WIDTH-1:0]   op_b;
    logic [SHAMT_W-1:0]      shamt;
    logic [2*DATA_WIDTH-1:0] prod_s;
    logic [2*DATA_WIDTH-1:0] prod_u;

    logic [DATA_WIDTH-1:0] alu_result;
    logic                  hilo_wr;
    logic [DATA_WIDTH-1:0] hi_res;
    logic [DATA_WIDTH-1:0] lo_res;
    logic                  div_start;
    logic                  div_signed;
    logic                  div_busy;
    logic                  div_done;
    logic [DATA_WIDTH-1:0] div_quot;
    logic [DATA_WIDTH-1:0] div_rem;

    assign op_a  = reg_rd_data1_in;
    assign op_b  = reg_rd_data2_in;
    assign shamt = op_a[SHAMT_W-1:0];

    // Low 2N bits of the sign-extended product equal the signed 2N-bit product.
    assign prod_s = {{DATA_WIDTH{op_a[DATA_WIDTH-1]}}, op_a} * {{DATA_WIDTH{op_b[DATA_WIDTH-1]}}, op_b};
    assign prod_u = {{DATA_WIDTH{1'b0}}, op_a} * {{DATA_WIDTH{1'b0}}, op_b};

    div_unit #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_div (
        .clk       (clk),
        .rst       (rst),
        .start     (div_start),
        .signed_op (div_signed),
        .op_a      (op_a),
        .op_b      (op_b),
        .flush     (flush),
        .hold      (ex_stall),
        .busy      (div_busy),
        .done      (div_done),
        .quotient  (div_quot),
        .remainder (div_rem)
    );

    always_comb begin
        alu_result = '0;
        hilo_wr    = 1'b0;
        hi_res     = '0;
        lo_res     = '0;
        div_start  = 1'b0;
        div_signed = 1'b0;
        case (alusel_in)
            ALUSEL_LOGIC: begin
                case (aluop_in)
                    ALUOP_AND: alu_result = op_a & op_b;
                    ALUOP_OR:  alu_result = op_a | op_b;
                    ALUOP_XOR: alu_result = op_a ^ op_b;
                    ALUOP_NOR: alu_result = ~(op_a | op_b);
                    default:   alu_result = '0;
                endcase
            end
            ALUSEL_SHIFT: begin
                case (aluop_in)
                    ALUOP_SLL: alu_result = op_b << shamt;
                    ALUOP_SRL: alu_result = op_b >> shamt;
                    ALUOP_SRA: alu_result = $unsigned($signed(op_b) >>> shamt);
                    default:   alu_result = '0;
                endcase
            end
            ALUSEL_MOVE: begin
                case (aluop_in)
                    ALUOP_MFHI: alu_result = hi_in;
                    ALUOP_MFLO: alu_result = lo_in;
                    default:    alu_result = '0;
                endcase
            end
            ALUSEL_ARITH: begin
                case (aluop_in)
                    ALUOP_ADDU: alu_result = op_a + op_b;
                    ALUOP_SUBU: alu_result = op_a - op_b;
                    ALUOP_SLT:  alu_result = {{(DATA_WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
                    ALUOP_SLTU: alu_result = {{(DATA_WIDTH-1){1'b0}}, (op_a < op_b)};
                    ALUOP_MULT: begin
                        hilo_wr          = 1'b1;
                        {hi_res, lo_res} = prod_s;
                    end
                    ALUOP_MULTU: begin
                        hilo_wr          = 1'b1;
                        {hi_res, lo_res} = prod_u;
                    end
                    ALUOP_DIV, ALUOP_DIVU: begin
                        div_start  = 1'b1;
                        div_signed = (aluop_in == ALUOP_DIV);
                        hilo_wr    = div_done;
                        hi_res     = div_done ? div_rem : '0;
                        lo_res     = div_done ? div_quot : '0;
                    end
                    default: alu_result = '0;
                endcase
            end
            default: alu_result = '0;
        endcase
    end

    // Everything downstream sees zeros while reset is asserted.
    assign reg_wr_addr_out = rst ? '0 : reg_wr_addr_in;
    assign reg_wr_en_out   = rst ? 1'b0 : reg_wr_en_in;
    assign reg_wr_data_out = rst ? '0 : alu_result;
    assign hilo_wr_en_out  = rst ? 1'b0 : hilo_wr;
    assign hi_out          = rst ? '0 : hi_res;
    assign lo_out          = rst ? '0 : lo_res;
    assign stall_req       = rst ? 1'b0 : div_busy;

endmodule

// File: tb/tb_ex_stage.sv
// tb/tb_ex_stage.sv - directed self-checking bench for ex_stage
module tb_ex_stage;
    import mips_defines_pkg::*;

    logic        clk;
    logic        rst;
    logic        ex_stall;
    logic        flush;
    logic [4:0]  reg_wr_addr_in;
    logic        reg_wr_en_in;
    logic [31:0] reg_rd_data1_in;
    logic [31:0] reg_rd_data2_in;
    logic [2:0]  alusel_in;
    logic [7:0]  aluop_in;
    logic [31:0] hi_in;
    logic [31:0] lo_in;
    logic [4:0]  reg_wr_addr_out;
    logic        reg_wr_en_out;
    logic [31:0] reg_wr_data_out;
    logic        hilo_wr_en_out;
    logic [31:0] hi_out;
    logic [31:0] lo_out;
    logic        stall_req;

    int n_checks = 0;
    int n_fail   = 0;
    int n;

    ex_stage dut (
        .clk             (clk),
        .rst             (rst),
        .ex_stall        (ex_stall),
        .flush           (flush),
        .reg_wr_addr_in  (reg_wr_addr_in),
        .reg_wr_en_in    (reg_wr_en_in),
        .reg_rd_data1_in (reg_rd_data1_in),
        .reg_rd_data2_in (reg_rd_data2_in),
        .alusel_in       (alusel_in),
        .aluop_in        (aluop_in),
        .hi_in           (hi_in),
        .lo_in           (lo_in),
        .reg_wr_addr_out (reg_wr_addr_out),
        .reg_wr_en_out   (reg_wr_en_out),
        .reg_wr_data_out (reg_wr_data_out),
        .hilo_wr_en_out  (hilo_wr_en_out),
        .hi_out          (hi_out),
        .lo_out          (lo_out),
        .stall_req       (stall_req)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [2:0] sel, input logic [7:0] op,
                         input logic [31:0] a, input logic [31:0] b);
        alusel_in       = sel;
        aluop_in        = op;
        reg_rd_data1_in = a;
        reg_rd_data2_in = b;
    endtask

    task automatic alu_check(input string tag, input logic [2:0] sel, input logic [7:0] op,
                             input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
        @(negedge clk);
        drive(sel, op, a, b);
        #1;
        check(tag, reg_wr_data_out, exp);
    endtask

    // Counts stalled cycles from the current sample point until stall_req drops.
    task automatic wait_div(output int cnt);
        cnt = 0;
        while (stall_req && cnt < 100) begin
            cnt++;
            @(negedge clk);
            #1;
        end
    endtask

    initial begin
        rst = 1'b1; ex_stall = 1'b0; flush = 1'b0;
        reg_wr_addr_in = 5'd5; reg_wr_en_in = 1'b1;
        hi_in = 32'h1234_5678; lo_in = 32'h9ABC_DEF0;
        drive(ALUSEL_ARITH, ALUOP_ADDU, 32'd1, 32'd2);
        #2;
        check("rst_data", reg_wr_data_out, 0);
        check("rst_addr", reg_wr_addr_out, 0);
        check("rst_en", reg_wr_en_out, 0);
        check("rst_stall", stall_req, 0);
        check("rst_hilo", hilo_wr_en_out, 0);

        @(negedge clk);
        rst = 1'b0;
        drive(ALUSEL_ARITH, ALUOP_ADDU, 32'hFFFF_FFFF, 32'd2);
        #1;
        check("addu_wrap", reg_wr_data_out, 32'h1);
        check("addu_stall", stall_req, 0);
        check("addr_pass", reg_wr_addr_out, 5'd5);
        check("en_pass", reg_wr_en_out, 1);
        check("addu_hilo", hilo_wr_en_out, 0);

        alu_check("subu", ALUSEL_ARITH, ALUOP_SUBU, 32'd0, 32'd1, 32'hFFFF_FFFF);
        alu_check("slt", ALUSEL_ARITH, ALUOP_SLT, 32'hFFFF_FFFE, 32'd1, 32'd1);
        alu_check("sltu", ALUSEL_ARITH, ALUOP_SLTU, 32'hFFFF_FFFE, 32'd1, 32'd0);
        alu_check("and", ALUSEL_LOGIC, ALUOP_AND, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000);
        alu_check("or", ALUSEL_LOGIC, ALUOP_OR, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0);
        alu_check("xor", ALUSEL_LOGIC, ALUOP_XOR, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0);
        alu_check("nor", ALUSEL_LOGIC, ALUOP_NOR, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h000F_000F);
        alu_check("sll", ALUSEL_SHIFT, ALUOP_SLL, 32'd4, 32'h8000_0001, 32'h0000_0010);
        alu_check("srl", ALUSEL_SHIFT, ALUOP_SRL, 32'd4, 32'h8000_0010, 32'h0800_0001);
        alu_check("sra_shamt5", ALUSEL_SHIFT, ALUOP_SRA, 32'h24, 32'h8000_0010, 32'hF800_0001);
        alu_check("mfhi", ALUSEL_MOVE, ALUOP_MFHI, 32'd0, 32'd0, 32'h1234_5678);
        alu_check("mflo", ALUSEL_MOVE, ALUOP_MFLO, 32'd0, 32'd0, 32'h9ABC_DEF0);
        alu_check("unknown", ALUSEL_ARITH, 8'hFF, 32'd3, 32'd4, 32'd0);
        check("unknown_hilo", hilo_wr_en_out, 0);

        @(negedge clk);
        reg_wr_en_in = 1'b0;
        drive(ALUSEL_ARITH, ALUOP_MULT, 32'hFFFF_FFFD, 32'd5);
        #1;
        check("mult_hi", hi_out, 32'hFFFF_FFFF);
        check("mult_lo", lo_out, 32'hFFFF_FFF1);
        check("mult_we", hilo_wr_en_out, 1);
        check("mult_reg_en", reg_wr_en_out, 0);
        @(negedge clk);
        drive(ALUSEL_ARITH, ALUOP_MULTU, 32'hFFFF_FFFD, 32'd5);
        #1;
        check("multu_hi", hi_out, 32'h4);
        check("multu_lo", lo_out, 32'hFFFF_FFF1);

        // DIV -7 / 2
        @(negedge clk);
        drive(ALUSEL_ARITH, ALUOP_DIV, 32'hFFFF_FFF9, 32'd2);
        #1;
        wait_div(n);
        check("div_stall_cycles", n, 33);
        check("div_lo", lo_out, 32'hFFFF_FFFD);
        check("div_hi", hi_out, 32'hFFFF_FFFF);
        check("div_we", hilo_wr_en_out, 1);
        @(negedge clk);
        drive(ALUSEL_NOP, 8'h00, 32'd0, 32'd0);

        // DIVU 100 / 7 held in DONE
        @(negedge clk);
        drive(ALUSEL_ARITH, ALUOP_DIVU, 32'd100, 32'd7);
        #1;
        wait_div(n);
        check("divu_stall_cycles", n, 33);
        ex_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("hold_lo", lo_out, 32'd14);
            check("hold_hi", hi_out, 32'd2);
            check("hold_we", hilo_wr_en_out, 1);
            check("hold_stall", stall_req, 0);
            @(negedge clk);
        end
        ex_stall = 1'b0;
        #1;
        check("release_lo", lo_out, 32'd14);
        check("release_hi", hi_out, 32'd2);

        // Next divide starting immediately proves return to IDLE
        @(negedge clk);
        drive(ALUSEL_ARITH, ALUOP_DIVU, 32'd100, 32'd0);
        #1;
        wait_div(n);
        check("div0_stall_cycles", n, 1);
        check("div0_lo", lo_out, 32'hFFFF_FFFF);
        check("div0_hi", hi_out, 32'd100);
        check("div0_we", hilo_wr_en_out, 1);
        @(negedge clk);
        drive(ALUSEL_NOP, 8'h00, 32'd0, 32'd0);

        // Flush during RUN
        @(negedge clk);
        drive(ALUSEL_ARITH, ALUOP_DIV, 32'hFFFF_FFF9, 32'd2);
        for (int i = 0; i < 11; i++) @(negedge clk);
        #1;
        check("flush_pre_stall", stall_req, 1);
        flush = 1'b1;
        drive(ALUSEL_NOP, 8'h00, 32'd0, 32'd0);
        #1;
        check("flush_stall", stall_req, 0);
        check("flush_we", hilo_wr_en_out, 0);
        @(negedge clk);
        flush = 1'b0;
        #1;
        check("post_flush_stall", stall_req, 0);
        check("post_flush_we", hilo_wr_en_out, 0);
        @(negedge clk);
        drive(ALUSEL_ARITH, ALUOP_DIVU, 32'd9, 32'd0);
        #1;
        wait_div(n);
        check("post_flush_div0_cycles", n, 1);
        check("post_flush_div0_hi", hi_out, 32'd9);
        @(negedge clk);
        drive(ALUSEL_NOP, 8'h00, 32'd0, 32'd0);

        // Async reset during RUN
        @(negedge clk);
        reg_wr_addr_in = 5'd9;
        reg_wr_en_in   = 1'b1;
        drive(ALUSEL_ARITH, ALUOP_DIV, 32'hFFFF_FFF9, 32'd2);
        for (int i = 0; i < 11; i++) @(negedge clk);
        #1;
        check("rst_pre_stall", stall_req, 1);
        rst = 1'b1;
        #1;
        check("midrst_stall", stall_req, 0);
        check("midrst_we", hilo_wr_en_out, 0);
        check("midrst_addr", reg_wr_addr_out, 0);
        check("midrst_en", reg_wr_en_out, 0);
        check("midrst_hi", hi_out, 0);
        check("midrst_lo", lo_out, 0);
        @(negedge clk);
        drive(ALUSEL_NOP, 8'h00, 32'd0, 32'd0);
        rst = 1'b0;
        #1;
        check("post_rst_stall", stall_req, 0);
        check("post_rst_addr", reg_wr_addr_out, 5'd9);
        @(negedge clk);
        drive(ALUSEL_ARITH, ALUOP_DIVU, 32'd100, 32'd0);
        #1;
        wait_div(n);
        check("post_rst_div0_cycles", n, 1);
        check("post_rst_div0_lo", lo_out, 32'hFFFF_FFFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
